// File: rtl/trace_fmt_pkg.sv
// Shared constants, encodings and helpers for the write-back trace line formatter.
package trace_fmt_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_ZERO   = 8'h30;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } fmt_state_e;

    typedef enum logic [3:0] {
        F_CARET,
        F_TIME,
        F_AT,
        F_PC,
        F_COLON,
        F_SP1,
        F_KIND,
        F_REG,
        F_ADDR,
        F_SP2,
        F_LT,
        F_EQ,
        F_SP3,
        F_DATA,
        F_HASH,
        F_END
    } fmt_field_e;

    // Lowercase hex: 'a' is 0x61, i.e. 0x57 + 10.
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        if (n < 4'd10) begin
            return CH_ZERO + {4'd0, n};
        end
        return 8'h57 + {4'd0, n};
    endfunction

    function automatic logic [3:0] nibble_sel(
        input logic [31:0] v,
        input logic [2:0]  idx
    );
        logic [31:0] w_v;
        w_v = v >> {idx, 2'b00};
        return w_v[3:0];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// 14-bit sequential double-dabble; bcd is valid while done is high.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        done,
    output logic [15:0] bcd
);

    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_run;
    logic        r_done;
    logic [15:0] w_adj;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    assign w_adj = {
        add3(r_bcd[15:12]),
        add3(r_bcd[11:8]),
        add3(r_bcd[7:4]),
        add3(r_bcd[3:0])
    };

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_bin  <= bin;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b1;
            r_done <= 1'b0;
        end else if (r_run) begin
            {r_bcd, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd13) begin
                r_run  <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: rtl/trace_line_formatter.sv
// Serialises one write-back event into a checker trace line,
// one ASCII character per clock.
module trace_line_formatter
    import trace_fmt_pkg::*;
#(
    parameter logic [7:0]  IDLE_CHAR = 8'h00,
    parameter logic [13:0] MAX_TIME  = 14'd9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic        ev_kind,
    input  logic [13:0] ev_time,
    input  logic [31:0] ev_pc,
    input  logic [4:0]  ev_reg,
    input  logic [31:0] ev_addr,
    input  logic [31:0] ev_data,
    output logic [7:0]  char,
    output logic        char_valid,
    output logic        busy
);

    fmt_state_e r_state;
    fmt_field_e r_field;
    logic [2:0] r_dig;
    logic [7:0] r_char;
    logic       r_char_valid;

    logic        r_kind;
    logic [31:0] r_pc;
    logic [4:0]  r_reg;
    logic [31:0] r_addr;
    logic [31:0] r_data;

    fmt_state_e  w_state_nx;
    fmt_field_e  w_field_nx;
    logic [2:0]  w_dig_nx;
    logic [7:0]  w_char_nx;
    logic        w_valid_nx;
    logic        w_emit;

    fmt_field_e  w_adv_field;
    logic [2:0]  w_adv_dig;
    logic [7:0]  w_cur_char;

    logic        w_xfer;
    logic [13:0] w_time_clamped;
    logic        w_bcd_done;
    logic [15:0] w_bcd;
    logic [1:0]  w_time_msd;
    logic [1:0]  w_reg_tens;
    logic [4:0]  w_reg_ones;

    assign ev_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign char       = r_char;
    assign char_valid = r_char_valid;

    assign w_xfer = ev_valid && (r_state == IDLE);
    assign w_time_clamped =
        (ev_time > MAX_TIME) ? MAX_TIME : ev_time;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (w_xfer),
        .bin   (w_time_clamped),
        .done  (w_bcd_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_kind <= ev_kind;
            r_pc   <= ev_pc;
            r_reg  <= ev_reg;
            r_addr <= ev_addr;
            r_data <= ev_data;
        end
    end

    // Leading-zero suppression: index of the most significant digit.
    always_comb begin
        w_time_msd = 2'd0;
        if (w_bcd[15:12] != 4'd0) begin
            w_time_msd = 2'd3;
        end else if (w_bcd[11:8] != 4'd0) begin
            w_time_msd = 2'd2;
        end else if (w_bcd[7:4] != 4'd0) begin
            w_time_msd = 2'd1;
        end
    end

    always_comb begin
        w_reg_tens = 2'd0;
        w_reg_ones = r_reg;
        if (r_reg >= 5'd30) begin
            w_reg_tens = 2'd3;
            w_reg_ones = r_reg - 5'd30;
        end else if (r_reg >= 5'd20) begin
            w_reg_tens = 2'd2;
            w_reg_ones = r_reg - 5'd20;
        end else if (r_reg >= 5'd10) begin
            w_reg_tens = 2'd1;
            w_reg_ones = r_reg - 5'd10;
        end
    end

    // Character at the cursor and where the cursor moves next.
    always_comb begin
        w_cur_char  = IDLE_CHAR;
        w_adv_field = r_field;
        w_adv_dig   = r_dig;
        unique case (r_field)
            F_CARET: begin
                w_cur_char  = CH_CARET;
                w_adv_field = F_TIME;
                w_adv_dig   = {1'b0, w_time_msd};
            end
            F_TIME: begin
                w_cur_char = CH_ZERO +
                    {4'd0, nibble_sel({16'd0, w_bcd}, r_dig)};
                if (r_dig == 3'd0) begin
                    w_adv_field = F_AT;
                end else begin
                    w_adv_dig = r_dig - 3'd1;
                end
            end
            F_AT: begin
                w_cur_char  = CH_AT;
                w_adv_field = F_PC;
                w_adv_dig   = 3'd7;
            end
            F_PC: begin
                w_cur_char = nibble_to_hex(nibble_sel(r_pc, r_dig));
                if (r_dig == 3'd0) begin
                    w_adv_field = F_COLON;
                end else begin
                    w_adv_dig = r_dig - 3'd1;
                end
            end
            F_COLON: begin
                w_cur_char  = CH_COLON;
                w_adv_field = F_SP1;
            end
            F_SP1: begin
                w_cur_char  = CH_SPACE;
                w_adv_field = F_KIND;
            end
            F_KIND: begin
                if (r_kind == KIND_MEM) begin
                    w_cur_char  = CH_STAR;
                    w_adv_field = F_ADDR;
                    w_adv_dig   = 3'd7;
                end else begin
                    w_cur_char  = CH_DOLLAR;
                    w_adv_field = F_REG;
                    w_adv_dig   = (r_reg >= 5'd10) ? 3'd1 : 3'd0;
                end
            end
            F_REG: begin
                if (r_dig[0]) begin
                    w_cur_char = CH_ZERO + {6'd0, w_reg_tens};
                end else begin
                    w_cur_char = CH_ZERO + {3'd0, w_reg_ones};
                end
                if (r_dig == 3'd0) begin
                    w_adv_field = F_SP2;
                end else begin
                    w_adv_dig = r_dig - 3'd1;
                end
            end
            F_ADDR: begin
                w_cur_char = nibble_to_hex(nibble_sel(r_addr, r_dig));
                if (r_dig == 3'd0) begin
                    w_adv_field = F_SP2;
                end else begin
                    w_adv_dig = r_dig - 3'd1;
                end
            end
            F_SP2: begin
                w_cur_char  = CH_SPACE;
                w_adv_field = F_LT;
            end
            F_LT: begin
                w_cur_char  = CH_LT;
                w_adv_field = F_EQ;
            end
            F_EQ: begin
                w_cur_char  = CH_EQ;
                w_adv_field = F_SP3;
            end
            F_SP3: begin
                w_cur_char  = CH_SPACE;
                w_adv_field = F_DATA;
                w_adv_dig   = 3'd7;
            end
            F_DATA: begin
                w_cur_char = nibble_to_hex(nibble_sel(r_data, r_dig));
                if (r_dig == 3'd0) begin
                    w_adv_field = F_HASH;
                end else begin
                    w_adv_dig = r_dig - 3'd1;
                end
            end
            F_HASH: begin
                w_cur_char  = CH_HASH;
                w_adv_field = F_END;
            end
            F_END: begin
                w_cur_char  = IDLE_CHAR;
                w_adv_field = F_END;
            end
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_field_nx = r_field;
        w_dig_nx   = r_dig;
        w_char_nx  = IDLE_CHAR;
        w_valid_nx = 1'b0;
        w_emit     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nx = CONV;
                    w_field_nx = F_CARET;
                    w_dig_nx   = 3'd0;
                end
            end
            CONV: begin
                if (w_bcd_done) begin
                    w_state_nx = EMIT;
                    w_emit     = 1'b1;
                end
            end
            EMIT: begin
                if (r_field == F_END) begin
                    w_state_nx = IDLE;
                end else begin
                    w_emit = 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        if (w_emit) begin
            w_char_nx  = w_cur_char;
            w_valid_nx = 1'b1;
            w_field_nx = w_adv_field;
            w_dig_nx   = w_adv_dig;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_field      <= F_CARET;
            r_dig        <= 3'd0;
            r_char       <= IDLE_CHAR;
            r_char_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_field      <= w_field_nx;
            r_dig        <= w_dig_nx;
            r_char       <= w_char_nx;
            r_char_valid <= w_valid_nx;
        end
    end

endmodule

// File: tb/tb_trace_line_formatter.sv
// Bench for trace_line_formatter: per-cycle model built from formatted strings.
module tb_trace_line_formatter;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_kind = 1'b0;
    logic [13:0] ev_time = '0;
    logic [31:0] ev_pc = '0;
    logic [4:0]  ev_reg = '0;
    logic [31:0] ev_addr = '0;
    logic [31:0] ev_data = '0;
    logic        ev_ready;
    logic [7:0]  ch;
    logic        char_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    logic [7:0] exp_char [MAXC];
    bit         exp_valid[MAXC];
    bit         exp_ready[MAXC];

    string q_lines[$];
    int    q_start[$];
    string cur;
    bit    in_line = 1'b0;

    trace_line_formatter dut (
        .clk        (clk),
        .reset      (reset),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_kind    (ev_kind),
        .ev_time    (ev_time),
        .ev_pc      (ev_pc),
        .ev_reg     (ev_reg),
        .ev_addr    (ev_addr),
        .ev_data    (ev_data),
        .char       (ch),
        .char_valid (char_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic string mk_line(
        input bit          kind,
        input int          t,
        input logic [31:0] pc,
        input int          r,
        input logic [31:0] addr,
        input logic [31:0] data
    );
        int tc;
        tc = (t > 9999) ? 9999 : t;
        if (kind)
            return $sformatf("^%0d@%08x: *%08x <= %08x#",
                             tc, pc, addr, data);
        return $sformatf("^%0d@%08x: $%0d <= %08x#", tc, pc, r, data);
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic chk_s(input string name, input string got,
                         input string want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got \"%s\" want \"%s\"", name, got, want);
        end
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_char[i]  = 8'h00;
            exp_valid[i] = 1'b0;
            exp_ready[i] = 1'b1;
        end
    end

    // Model: slot n is the output state visible after edge n.
    always @(posedge clk) begin
        string s;
        cyc++;
        if (reset) begin
            for (int i = cyc; i < MAXC; i++) begin
                exp_char[i]  = 8'h00;
                exp_valid[i] = 1'b0;
                exp_ready[i] = 1'b1;
            end
        end else if (ev_valid && exp_ready[cyc-1]) begin
            s = mk_line(ev_kind, int'(ev_time), ev_pc,
                        int'(ev_reg), ev_addr, ev_data);
            for (int j = 0; j < 15 + s.len(); j++)
                if (cyc + j < MAXC) exp_ready[cyc+j] = 1'b0;
            for (int k = 0; k < s.len(); k++) begin
                if (cyc + 15 + k < MAXC) begin
                    exp_char[cyc+15+k]  = s[k];
                    exp_valid[cyc+15+k] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            checks++;
            if (ch !== exp_char[cyc] || char_valid !== exp_valid[cyc]) begin
                errors++;
                $display("FAIL char slot %0d: got %02h/%0b want %02h/%0b",
                         cyc, ch, char_valid, exp_char[cyc], exp_valid[cyc]);
            end
            checks++;
            if (ev_ready !== exp_ready[cyc] ||
                busy !== ~exp_ready[cyc]) begin
                errors++;
                $display("FAIL hs slot %0d: ready/busy %0b/%0b want %0b/%0b",
                         cyc, ev_ready, busy, exp_ready[cyc], ~exp_ready[cyc]);
            end
        end
    end

    always @(negedge clk) begin
        if (char_valid === 1'b1) begin
            if (!in_line) begin
                in_line = 1'b1;
                cur = "";
                q_start.push_back(cyc);
            end
            cur = $sformatf("%s%c", cur, ch);
        end else if (in_line) begin
            in_line = 1'b0;
            q_lines.push_back(cur);
        end
    end

    task automatic send(input bit kind, input int t, input logic [31:0] pc,
                        input int r, input logic [31:0] addr,
                        input logic [31:0] data, input bit keep);
        int w;
        w = 0;
        ev_valid = 1'b1;
        ev_kind  = kind;
        ev_time  = t[13:0];
        ev_pc    = pc;
        ev_reg   = r[4:0];
        ev_addr  = addr;
        ev_data  = data;
        while (ev_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("send_ready", {63'd0, ev_ready}, 64'd1);
        @(negedge clk);
        if (!keep) ev_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (ev_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("idle_wait", {63'd0, ev_ready}, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_lines[8];
        int w;
        exp_lines[0] = "^123@00003000: $5 <= 0000abcd#";
        exp_lines[1] = "^0@00004ffc: *00002ff0 <= ffffffff#";
        exp_lines[2] = "^9999@80000000: $31 <= 12345678#";
        exp_lines[3] = "^9@00000010: $10 <= deadbeef#";
        exp_lines[4] = "^4567@fffffffc: *cafef00d <= 00000000#";
        exp_lines[5] = "^77@0000010";
        exp_lines[6] = "^1000@00000020: $0 <= 0000000a#";
        exp_lines[7] = "^1@00000000: *00000000 <= 00000000#";

        chk_s("model_reg", mk_line(0, 123, 32'h3000, 5, 0, 32'hABCD),
              exp_lines[0]);
        chk_s("model_clamp", mk_line(0, 12000, 32'h8000_0000, 31, 0,
              32'h1234_5678), exp_lines[2]);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_char", {56'd0, ch}, 64'h00);
        chk("rst_valid", {63'd0, char_valid}, 64'd0);
        chk("rst_ready", {63'd0, ev_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        send(0, 123, 32'h3000, 5, 0, 32'hABCD, 0);
        wait_idle();
        send(1, 0, 32'h4ffc, 0, 32'h2ff0, 32'hFFFF_FFFF, 0);
        wait_idle();
        send(0, 12000, 32'h8000_0000, 31, 0, 32'h1234_5678, 0);
        wait_idle();

        send(0, 9, 32'h10, 10, 0, 32'hDEAD_BEEF, 1);
        send(1, 4567, 32'hFFFF_FFFC, 3, 32'hCAFE_F00D, 0, 0);
        wait_idle();

        send(0, 77, 32'h100, 7, 0, 7, 0);
        w = 0;
        while (char_valid !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("mid_first_char", {63'd0, char_valid}, 64'd1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_char", {56'd0, ch}, 64'h00);
        chk("mid_rst_valid", {63'd0, char_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, ev_ready}, 64'd1);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);

        send(0, 1000, 32'h20, 0, 0, 32'h0A, 0);
        wait_idle();
        send(1, 1, 0, 0, 0, 0, 0);
        wait_idle();
        repeat (3) @(negedge clk);

        chk("line_count", 64'(q_lines.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk_s($sformatf("line%0d", i),
                  (i < q_lines.size()) ? q_lines[i] : "<none>",
                  exp_lines[i]);
        end
        if (q_lines.size() >= 8) begin
            chk("len_reg", 64'(q_lines[0].len()), 64'd30);
            chk("len_mem", 64'(q_lines[7].len()), 64'd35);
            chk("b2b_spacing", 64'(q_start[4] - q_start[3]), 64'd45);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_line_formatter.md
# trace_line_formatter

Serialises one CPU write-back event per handshake into the ASCII trace line consumed by the downstream CPU-output checker, one character per clock. Emits `^<time>@<pc>: $<reg> <= <data>#` for register writes and `^<time>@<pc>: *<addr> <= <data>#` for memory writes. The format uses decimal time and register number, and 8-digit lowercase hex for pc, addr and data. Sits between the CPU model's write-back port and the checker's `char` input.

## Interface
- `IDLE_CHAR`, 8'h00 — character driven while no line is being emitted.
- `MAX_TIME`, 9999 — largest time printed; larger inputs clamp to this value.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `ev_valid`  in  1  event offered.
- `ev_ready`  out  1  high only in IDLE; an event transfers on a rising edge where `ev_valid && ev_ready`.
- `ev_kind`  in  1  0 = register write (`$`), 1 = memory write (`*`).
- `ev_time`  in  14  time value, binary.
- `ev_pc`  in  32  instruction address.
- `ev_reg`  in  5  register number (used when kind = 0).
- `ev_addr`  in  32  memory address (used when kind = 1).
- `ev_data`  in  32  written value.
- `char`  out  8  current character; `IDLE_CHAR` when not emitting.
- `char_valid`  out  1  high while `char` belongs to a line.
- `busy`  out  1  high from acceptance until the cycle after `#`.

## Operation
- On transfer, latch all `ev_*` fields and clamp the time to `MAX_TIME`.
- States:
  - IDLE → CONV on transfer.
  - CONV → EMIT after 14 double-dabble iterations, which produce 4 BCD time digits.
  - EMIT → IDLE on the cycle `#` is presented.
- Time printing: suppress leading zeros; always print at least one digit, so 0 → "0" and 9999 → "9999".
- Register number printing: decimal, 1–2 digits (0..31). Tens digit comes from compares at ≥10/≥20/≥30; no leading zero.
- Hex fields: always 8 digits, MSB nibble first, lowercase a–f; leading zeros kept.
- Field separators are fixed: exactly one space after `:`, then ` <= ` (space, `<`, `=`, space), then data, then `#`.
- EMIT uses a field counter plus a digit counter; each character is registered, one per clock, with no gaps.
- Line length = 25 + time digits + (kind = 0 ? 1 + reg digits : 9). Examples:
  - time 123, reg 5 → 30 characters.
  - time 1, mem → 35 characters.
- Events with `ev_valid` low are ignored. Fields presented with `ev_valid` high but `ev_ready` low are not sampled.
- Reset mid-conversion or mid-line: the line is abandoned, with no `#` emitted. Next cycle: `char = IDLE_CHAR`, `char_valid = 0`, `busy = 0`, `ev_ready = 1`.

## Timing
- Reset values: `char = IDLE_CHAR`, `char_valid = 0`, `busy = 0`, `ev_ready = 1`.
- Transfer at edge E0.
- CONV occupies edges E1..E14.
- `^` is visible after E15, and character k of the line is visible after E15+k.
- After `#` is shown, the next edge returns to IDLE: `char = IDLE_CHAR`, `char_valid = 0`, `ev_ready = 1`. This guarantees one filler cycle between lines.
- Earliest next transfer is the edge ending that filler cycle.
- Minimum event-to-event spacing = 16 + line length cycles.
- No output back-pressure: the consumer samples every cycle.

## Structure
- Package `trace_fmt_pkg` holds:
  - character constants `CH_CARET`, `CH_AT`, `CH_COLON`, `CH_SPACE`, `CH_DOLLAR`, `CH_STAR`, `CH_LT`, `CH_EQ`, `CH_HASH`;
  - the `KIND_GRF`/`KIND_MEM` encoding;
  - the state enum IDLE/CONV/EMIT;
  - the field enum used by the EMIT sequencer;
  - a `nibble_to_hex` function.
- Sub-module `bin2bcd_seq`: 14-bit sequential double-dabble.
  - Ports: `start`, `bin[13:0]`, `done`, `bcd[15:0]`.
  - Fixed 14-cycle latency; its state clears on `reset`.

## Test plan
- kind = 0, time = 123, pc = 0x3000, reg = 5, data = 0xABCD → `^123@00003000: $5 <= 0000abcd#`. 30 characters with `char_valid` high, first character after E15.
- kind = 1, time = 0, pc = 0x4ffc, addr = 0x2ff0, data = 0xFFFFFFFF → `^0@00004ffc: *00002ff0 <= ffffffff#`. Time prints as a single "0".
- time = 12000 (clamp), reg = 31 → time printed as "9999", register printed as "31".
- `ev_valid` held high for two events → second transfer occurs only after the filler cycle. No character is dropped or duplicated, and exactly one `IDLE_CHAR` cycle separates the lines.
- Reset asserted at character 10 of a line → next cycle `char = 00`, `char_valid = 0`, `ev_ready = 1`. A fresh event then produces a complete line.
- Loopback: drive the output `char` stream into the checker. For in-range pc, addr and even time, it reports format 01/10 with error code 0 on the cycle after `#`.
